sipo_deserializer: RTL and testbench

Parametrised serial-in/parallel-out deserializer, the next generation of the fixed 8-bit SIPO used in the decoder path. It shifts qualified serial bits into a WIDTH-bit word, selects bit order, and optionally checks even parity. It resynchronises on a frame-start strobe and delivers completed words through a valid/ready output holding register with overrun detection. It sits between the serial line front-end and the decoder's word-level logic.

---
 rtl/sipo_deserializer.sv | 136 +++++++++++++
 tb/tb_sipo_deserializer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with selectable bit order and a valid/ready holding register.
// Define SIPO_DESERIALIZER_PARITY_CHECK_EN to add a trailing even-parity bit to each frame.
module sipo_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         serialIn,
    input  logic                         bitValid,
    input  logic                         frameStart,
    input  logic                         clearOverrun,
    output logic [WIDTH-1:0]             parallelOut,
    output logic                         wordValid,
    input  logic                         wordReady,
    output logic                         parityError,
    output logic                         overrun,
    output logic [$clog2(WIDTH+2)-1:0]   bitCount
);

    localparam int CNT_W = $clog2(WIDTH + 2);
`ifdef SIPO_DESERIALIZER_PARITY_CHECK_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] new_word;
    logic             complete;
    logic             hold_free;
    logic             is_data;
`ifdef SIPO_DESERIALIZER_PARITY_CHECK_EN
    logic             par_q, par_d;
    logic             perr_q, perr_d;
`endif

    // NOTE: every signal gets its default first so no path through the block leaves it unassigned (no latch).
    always_comb begin
        shift_d   = shift_q;
        out_d     = out_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        ovr_d     = ovr_q & ~clearOverrun;
        complete  = 1'b0;
        hold_free = ~valid_q | wordReady;
        shifted   = LSB_FIRST ? {serialIn, shift_q[WIDTH-1:1]} : {shift_q[WIDTH-2:0], serialIn};
`ifdef SIPO_DESERIALIZER_PARITY_CHECK_EN
        par_d    = par_q;
        perr_d   = perr_q;
        is_data  = frameStart | (cnt_q != CNT_W'(WIDTH));
        new_word = shift_q;
`else
        is_data  = 1'b1;
        new_word = shifted;
`endif

        if (bitValid) begin
            if (is_data) begin
                shift_d = shifted;
            end
`ifdef SIPO_DESERIALIZER_PARITY_CHECK_EN
            if (is_data) begin
                par_d = (frameStart || cnt_q == '0) ? serialIn : (par_q ^ serialIn);
            end
`endif
            if (frameStart) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q == LAST_IDX) begin
                cnt_d    = '0;
                complete = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (frameStart) begin
            cnt_d = '0;
        end

        // A word completing while the consumer still owes us a handshake is dropped.
        if (complete) begin
            if (hold_free) begin
                out_d   = new_word;
                valid_d = 1'b1;
`ifdef SIPO_DESERIALIZER_PARITY_CHECK_EN
                perr_d  = par_q ^ serialIn;
`endif
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && wordReady) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef SIPO_DESERIALIZER_PARITY_CHECK_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            shift_q <= shift_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
`ifdef SIPO_DESERIALIZER_PARITY_CHECK_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign parallelOut = out_q;
    assign wordValid   = valid_q;
    assign overrun     = ovr_q;
    assign bitCount    = cnt_q;
`ifdef SIPO_DESERIALIZER_PARITY_CHECK_EN
    assign parityError = perr_q;
`else
    assign parityError = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench for sipo_deserializer: one LSB-first and one MSB-first instance at WIDTH=8.
module tb_sipo_deserializer;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 2);
`ifdef SIPO_DESERIALIZER_PARITY_CHECK_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             perr;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset;
    logic             serial_in;
    logic             bv_l, bv_m;
    logic             frame_start;
    logic             clear_overrun;
    logic             word_ready;
    logic [WIDTH-1:0] parallel_out_l, parallel_out_m;
    logic             word_valid_l, word_valid_m;
    logic             parity_error_l, parity_error_m;
    logic             overrun_l, overrun_m;
    logic [CNT_W-1:0] bit_count_l, bit_count_m;

    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;
    int   pop_cycle_last = 0;
    int   pop_cycle_prev = 0;
    exp_t q_l[$];
    exp_t q_m[$];

    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    sipo_deserializer #(.WIDTH(WIDTH), .LSB_FIRST(1'b1)) dut_l (
        .clock(clock), .reset(reset), .serialIn(serial_in), .bitValid(bv_l),
        .frameStart(frame_start), .clearOverrun(clear_overrun),
        .parallelOut(parallel_out_l), .wordValid(word_valid_l), .wordReady(word_ready),
        .parityError(parity_error_l), .overrun(overrun_l), .bitCount(bit_count_l)
    );

    sipo_deserializer #(.WIDTH(WIDTH), .LSB_FIRST(1'b0)) dut_m (
        .clock(clock), .reset(reset), .serialIn(serial_in), .bitValid(bv_m),
        .frameStart(frame_start), .clearOverrun(clear_overrun),
        .parallelOut(parallel_out_m), .wordValid(word_valid_m), .wordReady(word_ready),
        .parityError(parity_error_m), .overrun(overrun_m), .bitCount(bit_count_m)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitors pop the scoreboard on every handshake, sampled 1ns after the falling edge.
    always @(negedge clock) begin
        exp_t e;
        #1;
        if (!reset && word_valid_l && word_ready) begin
            check("sb_l_pending", 32'(q_l.size() != 0), 32'd1);
            if (q_l.size() != 0) begin
                e = q_l.pop_front();
                check("word_l", 32'(parallel_out_l), 32'(e.data));
                check("perr_l", 32'(parity_error_l), 32'(e.perr));
                pop_cycle_prev = pop_cycle_last;
                pop_cycle_last = cycle;
            end
        end
    end

    always @(negedge clock) begin
        exp_t e;
        #1;
        if (!reset && word_valid_m && word_ready) begin
            check("sb_m_pending", 32'(q_m.size() != 0), 32'd1);
            if (q_m.size() != 0) begin
                e = q_m.pop_front();
                check("word_m", 32'(parallel_out_m), 32'(e.data));
                check("perr_m", 32'(parity_error_m), 32'(e.perr));
            end
        end
    end

    task automatic send_bit(input logic b, input logic fs, input bit to_m, input bit set_rdy);
        @(negedge clock);
        serial_in   = b;
        frame_start = fs;
        bv_l        = !to_m;
        bv_m        = to_m;
        if (set_rdy) word_ready = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            bv_l          = 1'b0;
            bv_m          = 1'b0;
            frame_start   = 1'b0;
            clear_overrun = 1'b0;
        end
    endtask

    // Bits go out w[0] first; with parity enabled an even-parity bit (optionally flipped) follows.
    task automatic send_word(input logic [WIDTH-1:0] w, input bit to_m, input bit flip, input bit rdy_on_last);
        for (int i = 0; i < FRAME_LEN; i++) begin
            logic b;
            if (i < WIDTH) b = w[i];
            else           b = (^w) ^ flip;
            send_bit(b, 1'b0, to_m, rdy_on_last && (i == FRAME_LEN - 1));
        end
    endtask

    initial begin
        reset = 1'b1; serial_in = 1'b0; bv_l = 1'b0; bv_m = 1'b0;
        frame_start = 1'b0; clear_overrun = 1'b0; word_ready = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_parallel", 32'(parallel_out_l), 32'h0);
        check("rst_valid", 32'(word_valid_l), 32'h0);
        check("rst_perr", 32'(parity_error_l), 32'h0);
        check("rst_overrun", 32'(overrun_l), 32'h0);
        check("rst_bitcount", 32'(bit_count_l), 32'h0);
        reset = 1'b0;

        // Bits 1,0,1,1,0,0,0,0 -> 8'h0D LSB-first, 8'hB0 MSB-first.
        word_ready = 1'b1;
        q_l.push_back('{data: 8'h0D, perr: 1'b0});
        send_word(8'h0D, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("t1_valid_latency", 32'(word_valid_l), 32'h1);
        idle(1);
        check("t1_valid_one_cycle", 32'(word_valid_l), 32'h0);

        q_m.push_back('{data: 8'hB0, perr: 1'b0});
        send_word(8'h0D, 1'b1, 1'b0, 1'b0);
        idle(1);
        check("t2_valid_m", 32'(word_valid_m), 32'h1);
        idle(2);

        // Second frame arrives while the first is still held.
        word_ready = 1'b0;
        q_l.push_back('{data: 8'hA5, perr: 1'b0});
        send_word(8'hA5, 1'b0, 1'b0, 1'b0);
        send_word(8'h3C, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("t3_overrun_set", 32'(overrun_l), 32'h1);
        check("t3_held_word", 32'(parallel_out_l), 32'hA5);
        clear_overrun = 1'b1;
        idle(1);
        check("t3_overrun_clear", 32'(overrun_l), 32'h0);
        word_ready = 1'b1;
        idle(2);

        // Back-to-back frames with continuous bits: deliveries FRAME_LEN cycles apart.
        q_l.push_back('{data: 8'h01, perr: 1'b0});
        q_l.push_back('{data: 8'h02, perr: 1'b0});
        send_word(8'h01, 1'b0, 1'b0, 1'b0);
        send_word(8'h02, 1'b0, 1'b0, 1'b0);
        idle(2);
        check("t4_gap", 32'(pop_cycle_last - pop_cycle_prev), 32'(FRAME_LEN));

        // Handshake and completion in the same cycle: new word loads, wordValid stays high.
        word_ready = 1'b0;
        q_l.push_back('{data: 8'h11, perr: 1'b0});
        q_l.push_back('{data: 8'h22, perr: 1'b0});
        send_word(8'h11, 1'b0, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b0, 1'b1);
        idle(1);
        check("t4b_valid_held", 32'(word_valid_l), 32'h1);
        check("t4b_no_overrun", 32'(overrun_l), 32'h0);
        idle(2);

        // Five junk bits, then a frame-start strobe with the first real bit of 8'h96.
        q_l.push_back('{data: 8'h96, perr: 1'b0});
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0, 1'b0);
        check("t5_bitcount_after_strobe", 32'(bit_count_l), 32'h1);
        begin
            logic [WIDTH-1:0] w;
            w = 8'h96;
            for (int i = 2; i < FRAME_LEN; i++) begin
                if (i < WIDTH) send_bit(w[i], 1'b0, 1'b0, 1'b0);
                else           send_bit(^w, 1'b0, 1'b0, 1'b0);
            end
        end
        idle(2);

        // Strobe without a valid bit drops the partial frame.
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        bv_l = 1'b0; frame_start = 1'b1;
        idle(1);
        check("t5_strobe_idle_bitcount", 32'(bit_count_l), 32'h0);

        // Held word plus a partial frame, then reset.
        word_ready = 1'b0;
        send_word(8'h5A, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("t6_pre_reset_valid", 32'(word_valid_l), 32'h1);
        check("t6_pre_reset_bitcount", 32'(bit_count_l), 32'h3);
        reset = 1'b1;
        idle(1);
        check("t6_reset_parallel", 32'(parallel_out_l), 32'h0);
        check("t6_reset_valid", 32'(word_valid_l), 32'h0);
        check("t6_reset_bitcount", 32'(bit_count_l), 32'h0);
        check("t6_reset_overrun", 32'(overrun_l), 32'h0);
        reset = 1'b0;
        word_ready = 1'b1;
        idle(1);

`ifdef SIPO_DESERIALIZER_PARITY_CHECK_EN
        q_l.push_back('{data: 8'h07, perr: 1'b0});
        send_word(8'h07, 1'b0, 1'b0, 1'b0);
        q_l.push_back('{data: 8'h07, perr: 1'b1});
        send_word(8'h07, 1'b0, 1'b1, 1'b0);
        idle(3);
`endif

        idle(2);
        check("sb_l_drained", 32'(q_l.size()), 32'h0);
        check("sb_m_drained", 32'(q_m.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
